// File: rtl/rom_prgmr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rom_prgmr_arbiter
//
// Sequences a game-ROM load from the SoC ROM-programmer PIO into the on-chip
// PRG and CHR ROMs. Each memory is single-ported and shared with NES reads
// (CPU on PRG, PPU on CHR). NES reads always win. Programmer writes are
// buffered in a small FIFO and drained in order. The NES is held in reset for
// the whole load. It is released a fixed time after the programmer goes quiet.
//
// Optional feature macro: ROM_ARB_CHECKSUM_EN
//   defined   -> prg_sum / chr_sum hold a mod-256 sum of the committed bytes
//   undefined -> no checksum logic; prg_sum / chr_sum are tied to 0
//
// Ports
//   Clk, Reset        MCLK-domain clock, synchronous active-high reset
//   prgmr_addr/data   programmer address and data byte
//   prgmr_prg_wren    PIO level; a rising edge requests one PRG write
//   prgmr_chr_wren    PIO level; a rising edge requests one CHR write
//   nes_prg_rd/addr   CPU read request and address (PRG)
//   nes_chr_rd/addr   PPU read request and address (CHR)
//   prg_mem_*         PRG memory address/data/write-enable (combinational mux)
//   chr_mem_*         CHR memory address/data/write-enable (combinational mux)
//   nes_reset         NES CPU/PPU reset, high during the load and hold
//   loading           high from the first accepted write until release
//   wr_count          writes committed in this load, saturating at 16'hFFFF
//   err_sticky        [0] FIFO overflow, [1] simultaneous PRG/CHR edge
//   prg_sum/chr_sum   checksums (see macro above)
//
// Release timing: if the last busy cycle (a push, or a non-empty FIFO, which
// includes the cycle of the last commit) is T, nes_reset is first seen low in
// cycle T + 1 + QUIET_CYCLES + RESET_HOLD.
// -----------------------------------------------------------------------------
module rom_prgmr_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int QUIET_CYCLES = 1024,
    parameter int RESET_HOLD   = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] prgmr_addr,
    input  logic [7:0]  prgmr_data,
    input  logic        prgmr_prg_wren,
    input  logic        prgmr_chr_wren,
    input  logic        nes_prg_rd,
    input  logic [15:0] nes_prg_addr,
    input  logic        nes_chr_rd,
    input  logic [15:0] nes_chr_addr,
    output logic [15:0] prg_mem_addr,
    output logic [7:0]  prg_mem_data,
    output logic        prg_mem_wren,
    output logic [15:0] chr_mem_addr,
    output logic [7:0]  chr_mem_data,
    output logic        chr_mem_wren,
    output logic        nes_reset,
    output logic        loading,
    output logic [15:0] wr_count,
    output logic [1:0]  err_sticky,
    output logic [7:0]  prg_sum,
    output logic [7:0]  chr_sum
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam int QL = QUIET_CYCLES - 1;
    localparam int HL = RESET_HOLD - 1;
    localparam logic [AW:0]   FIFO_FULL  = FIFO_DEPTH[AW:0];
    localparam logic [QW-1:0] QUIET_LAST = QL[QW-1:0];
    localparam logic [HW-1:0] HOLD_LAST  = HL[HW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // FIFO entry: [24] target (1 = CHR), [23:8] address, [7:0] data
    logic [24:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          r_prg_prev;
    logic          r_chr_prev;
    state_t        r_state;
    state_t        w_state_next;
    logic [QW-1:0] r_quiet_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_nes_reset;
    logic          r_loading;
    logic [15:0]   r_wr_count;
    logic [1:0]    r_err_sticky;

    logic          w_prg_edge;
    logic          w_chr_edge;
    logic          w_push;
    logic          w_dual;
    logic [24:0]   w_entry;
    logic          w_empty;
    logic          w_full;
    logic [24:0]   w_head;
    logic          w_head_chr;
    logic          w_pop;
    logic          w_accept;
    logic          w_overflow;
    logic          w_start;

    // A PRG edge has priority; the CHR half of a simultaneous pair is dropped.
    assign w_prg_edge = prgmr_prg_wren & ~r_prg_prev;
    assign w_chr_edge = prgmr_chr_wren & ~r_chr_prev;
    assign w_push     = w_prg_edge | w_chr_edge;
    assign w_dual     = w_prg_edge & w_chr_edge;
    assign w_entry    = {~w_prg_edge, prgmr_addr, prgmr_data};

    assign w_empty    = (r_count == {(AW+1){1'b0}});
    assign w_full     = (r_count == FIFO_FULL);
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_head_chr = w_head[24];

    // The head commits only when its own memory is free of an NES read.
    assign w_pop      = ~Reset & ~w_empty & (w_head_chr ? ~nes_chr_rd : ~nes_prg_rd);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_overflow = w_push & w_full & ~w_pop;
    assign w_start    = (r_state == ST_IDLE) & w_push;

    // Previous wren levels for rising-edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prg_prev <= 1'b0;
            r_chr_prev <= 1'b0;
        end else begin
            r_prg_prev <= prgmr_prg_wren;
            r_chr_prev <= prgmr_chr_wren;
        end
    end

    // FIFO storage (data path only; validity is tracked by r_count)
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Load sequencer state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Load sequencer next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_push || !w_empty) begin
                    w_state_next = ST_LOAD;
                end else if (r_quiet_cnt == QUIET_LAST) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (w_push) begin
                    w_state_next = ST_LOAD;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Quiet and hold counters. Each counts only in its own state and restarts on
    // activity. Quiet reaching QUIET_CYCLES coincides with the move to HOLD.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_quiet_cnt <= {QW{1'b0}};
            r_hold_cnt  <= {HW{1'b0}};
        end else begin
            if (r_state == ST_LOAD && !w_push && w_empty) begin
                r_quiet_cnt <= r_quiet_cnt + {{(QW-1){1'b0}}, 1'b1};
            end else begin
                r_quiet_cnt <= {QW{1'b0}};
            end
            if (r_state == ST_HOLD && !w_push) begin
                r_hold_cnt <= r_hold_cnt + {{(HW-1){1'b0}}, 1'b1};
            end else begin
                r_hold_cnt <= {HW{1'b0}};
            end
        end
    end

    // Registered status outputs, write counter and sticky errors
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_nes_reset  <= 1'b0;
            r_loading    <= 1'b0;
            r_wr_count   <= 16'h0000;
            r_err_sticky <= 2'b00;
        end else begin
            r_nes_reset  <= (w_state_next != ST_IDLE);
            r_loading    <= (w_state_next != ST_IDLE);
            r_err_sticky <= r_err_sticky | {w_dual, w_overflow};
            if (w_start) begin
                r_wr_count <= {15'h0000, w_pop};
            end else if (w_pop && r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'h0001;
            end
        end
    end

`ifdef ROM_ARB_CHECKSUM_EN
    logic [7:0] r_prg_sum;
    logic [7:0] r_chr_sum;

    // Running mod-256 sums of committed bytes, restarted with each new load
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prg_sum <= 8'h00;
            r_chr_sum <= 8'h00;
        end else if (w_start) begin
            r_prg_sum <= 8'h00;
            r_chr_sum <= 8'h00;
        end else if (w_pop) begin
            if (w_head_chr) begin
                r_chr_sum <= r_chr_sum + w_head[7:0];
            end else begin
                r_prg_sum <= r_prg_sum + w_head[7:0];
            end
        end
    end

    assign prg_sum = r_prg_sum;
    assign chr_sum = r_chr_sum;
`else
    assign prg_sum = 8'h00;
    assign chr_sum = 8'h00;
`endif

    // Memory port mux. A commit implies the matching NES read is idle, so the
    // NES address is presented whenever the head is not writing this memory.
    always_comb begin
        prg_mem_addr = nes_prg_addr;
        prg_mem_data = 8'h00;
        prg_mem_wren = 1'b0;
        chr_mem_addr = nes_chr_addr;
        chr_mem_data = 8'h00;
        chr_mem_wren = 1'b0;
        if (Reset) begin
            prg_mem_addr = 16'h0000;
            chr_mem_addr = 16'h0000;
        end else if (w_pop && !w_head_chr) begin
            prg_mem_addr = w_head[23:8];
            prg_mem_data = w_head[7:0];
            prg_mem_wren = 1'b1;
        end else if (w_pop && w_head_chr) begin
            chr_mem_addr = w_head[23:8];
            chr_mem_data = w_head[7:0];
            chr_mem_wren = 1'b1;
        end else begin
            prg_mem_wren = 1'b0;
            chr_mem_wren = 1'b0;
        end
    end

    assign nes_reset  = r_nes_reset;
    assign loading    = r_loading;
    assign wr_count   = r_wr_count;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_rom_prgmr_arbiter.sv
`timescale 1ns/1ps
module tb_rom_prgmr_arbiter;

    localparam int DEPTH = 4;
    localparam int QC    = 1024;
    localparam int RH    = 16;
`ifdef ROM_ARB_CHECKSUM_EN
    localparam logic [7:0] EXP_SUM3 = 8'h11;
`else
    localparam logic [7:0] EXP_SUM3 = 8'h00;
`endif

    logic        Clk;
    logic        Reset;
    logic [15:0] prgmr_addr;
    logic [7:0]  prgmr_data;
    logic        prgmr_prg_wren;
    logic        prgmr_chr_wren;
    logic        nes_prg_rd;
    logic [15:0] nes_prg_addr;
    logic        nes_chr_rd;
    logic [15:0] nes_chr_addr;
    logic [15:0] prg_mem_addr;
    logic [7:0]  prg_mem_data;
    logic        prg_mem_wren;
    logic [15:0] chr_mem_addr;
    logic [7:0]  chr_mem_data;
    logic        chr_mem_wren;
    logic        nes_reset;
    logic        loading;
    logic [15:0] wr_count;
    logic [1:0]  err_sticky;
    logic [7:0]  prg_sum;
    logic [7:0]  chr_sum;

    rom_prgmr_arbiter #(.FIFO_DEPTH(DEPTH), .QUIET_CYCLES(QC), .RESET_HOLD(RH)) dut (
        .Clk(Clk), .Reset(Reset),
        .prgmr_addr(prgmr_addr), .prgmr_data(prgmr_data),
        .prgmr_prg_wren(prgmr_prg_wren), .prgmr_chr_wren(prgmr_chr_wren),
        .nes_prg_rd(nes_prg_rd), .nes_prg_addr(nes_prg_addr),
        .nes_chr_rd(nes_chr_rd), .nes_chr_addr(nes_chr_addr),
        .prg_mem_addr(prg_mem_addr), .prg_mem_data(prg_mem_data), .prg_mem_wren(prg_mem_wren),
        .chr_mem_addr(chr_mem_addr), .chr_mem_data(chr_mem_data), .chr_mem_wren(chr_mem_wren),
        .nes_reset(nes_reset), .loading(loading), .wr_count(wr_count),
        .err_sticky(err_sticky), .prg_sum(prg_sum), .chr_sum(chr_sum)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // stimulus for the next cycle, applied on the falling edge
    logic        s_rst, s_prg_wren, s_chr_wren, s_prd, s_crd;
    logic [15:0] s_paddr, s_prd_addr, s_crd_addr;
    logic [7:0]  s_pdata;

    // reference model: pending writes as a queue, load activity as cycle numbers
    typedef struct packed {
        logic        tgt;   // 0 PRG, 1 CHR
        logic [15:0] addr;
        logic [7:0]  data;
    } ent_t;

    ent_t        m_q[$];
    logic        m_prev_prg, m_prev_chr, m_valid, m_have_busy;
    int          m_wr, m_cycle, m_last_busy;
    logic [1:0]  m_err;
    logic [7:0]  m_psum, m_csum;

    int checks;
    int errors;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s obs=%0h exp=%0h cycle=%0d", tag, obs, exp, m_cycle);
        end
    endtask

    task automatic set_idle();
        s_rst = 1'b0; s_prg_wren = 1'b0; s_chr_wren = 1'b0;
        s_prd = 1'b0; s_crd = 1'b0;
        s_paddr = 16'h0000; s_pdata = 8'h00;
        s_prd_addr = 16'h0000; s_crd_addr = 16'h0000;
    endtask

    task automatic step();
        ent_t        h;
        ent_t        n;
        logic        has, pop, pe, ce, act, busy, e_pw, e_cw;
        logic [15:0] e_pa, e_ca;
        logic [7:0]  e_pd, e_cd;
        @(negedge Clk);
        Reset = s_rst; prgmr_addr = s_paddr; prgmr_data = s_pdata;
        prgmr_prg_wren = s_prg_wren; prgmr_chr_wren = s_chr_wren;
        nes_prg_rd = s_prd; nes_prg_addr = s_prd_addr;
        nes_chr_rd = s_crd; nes_chr_addr = s_crd_addr;
        #1;
        has = (m_q.size() != 0);
        h = '0;
        if (has) h = m_q[0];
        pop  = !s_rst && has && (h.tgt ? !s_crd : !s_prd);
        e_pw = pop && !h.tgt;
        e_cw = pop && h.tgt;
        e_pa = s_rst ? 16'h0000 : (e_pw ? h.addr : s_prd_addr);
        e_ca = s_rst ? 16'h0000 : (e_cw ? h.addr : s_crd_addr);
        e_pd = e_pw ? h.data : 8'h00;
        e_cd = e_cw ? h.data : 8'h00;
        check_val("prg_wren", prg_mem_wren, e_pw);
        check_val("prg_addr", prg_mem_addr, e_pa);
        check_val("prg_data", prg_mem_data, e_pd);
        check_val("chr_wren", chr_mem_wren, e_cw);
        check_val("chr_addr", chr_mem_addr, e_ca);
        check_val("chr_data", chr_mem_data, e_cd);
        act = m_have_busy && ((m_cycle - m_last_busy) <= QC + RH);
        if (m_valid) begin
            check_val("nes_reset", nes_reset, act);
            check_val("loading", loading, act);
            check_val("wr_count", wr_count, m_wr);
            check_val("err_sticky", err_sticky, m_err);
            check_val("prg_sum", prg_sum, m_psum);
            check_val("chr_sum", chr_sum, m_csum);
        end
        if (s_rst) begin
            m_q.delete();
            m_prev_prg = 1'b0; m_prev_chr = 1'b0;
            m_wr = 0; m_err = 2'b00; m_psum = 8'h00; m_csum = 8'h00;
            m_have_busy = 1'b0; m_valid = 1'b1;
        end else begin
            pe = s_prg_wren && !m_prev_prg;
            ce = s_chr_wren && !m_prev_chr;
            busy = pe || ce || has;
            if ((pe || ce) && !act) begin
                m_wr = 0; m_psum = 8'h00; m_csum = 8'h00;
            end
            if (pop) begin
                void'(m_q.pop_front());
                if (m_wr < 65535) m_wr++;
`ifdef ROM_ARB_CHECKSUM_EN
                if (h.tgt) m_csum = m_csum + h.data;
                else       m_psum = m_psum + h.data;
`endif
            end
            if (pe || ce) begin
                if (pe && ce) m_err[1] = 1'b1;
                n.tgt = !pe; n.addr = s_paddr; n.data = s_pdata;
                if (m_q.size() < DEPTH) m_q.push_back(n);
                else m_err[0] = 1'b1;
            end
            if (busy) begin
                m_have_busy = 1'b1;
                m_last_busy = m_cycle;
            end
            m_prev_prg = s_prg_wren; m_prev_chr = s_chr_wren;
        end
        m_cycle++;
    endtask

    task automatic do_reset();
        s_rst = 1'b1; step(); s_rst = 1'b0; step();
    endtask

    task automatic prg_edge(input logic [15:0] a, input logic [7:0] d);
        s_paddr = a; s_pdata = d; s_prg_wren = 1'b1; step();
        s_prg_wren = 1'b0; step();
    endtask

    initial begin
        int t_last;
        int fall;
        checks = 0; errors = 0;
        m_valid = 1'b0; m_cycle = 0; m_last_busy = 0; m_have_busy = 1'b0;
        m_prev_prg = 1'b0; m_prev_chr = 1'b0; m_wr = 0; m_err = 2'b00;
        m_psum = 8'h00; m_csum = 8'h00;
        set_idle();
        s_rst = 1'b1; step(); step();
        s_rst = 1'b0; step();
        check_val("rst_nes_reset", nes_reset, 1'b0);
        check_val("rst_wr_count", wr_count, 16'h0000);

        // single PRG write 8000/A9
        s_paddr = 16'h8000; s_pdata = 8'hA9; s_prg_wren = 1'b1; step();
        step();
        check_val("t1_wren", prg_mem_wren, 1'b1);
        check_val("t1_addr", prg_mem_addr, 16'h8000);
        check_val("t1_data", prg_mem_data, 8'hA9);
        check_val("t1_nes_reset", nes_reset, 1'b1);
        check_val("t1_loading", loading, 1'b1);
        s_prg_wren = 1'b0; step();
        check_val("t1_wr_count", wr_count, 16'h0001);

        // two CHR writes stalled behind 5 PPU read cycles
        s_crd = 1'b1; s_crd_addr = 16'h1234;
        s_paddr = 16'h0000; s_pdata = 8'h11; s_chr_wren = 1'b1; step();
        s_chr_wren = 1'b0; step();
        check_val("t2_stall_wren", chr_mem_wren, 1'b0);
        s_paddr = 16'h0001; s_pdata = 8'h22; s_chr_wren = 1'b1; step();
        check_val("t2_stall_addr", chr_mem_addr, 16'h1234);
        s_chr_wren = 1'b0; step();
        step();
        check_val("t2_stall_wren2", chr_mem_wren, 1'b0);
        s_crd = 1'b0; step();
        check_val("t2_c0_wren", chr_mem_wren, 1'b1);
        check_val("t2_c0_addr", chr_mem_addr, 16'h0000);
        check_val("t2_c0_data", chr_mem_data, 8'h11);
        step();
        check_val("t2_c1_wren", chr_mem_wren, 1'b1);
        check_val("t2_c1_addr", chr_mem_addr, 16'h0001);
        check_val("t2_c1_data", chr_mem_data, 8'h22);

        // overflow: 6 PRG edges while the CPU holds PRG
        do_reset();
        s_prd = 1'b1; s_prd_addr = 16'hC000;
        for (int i = 0; i < 6; i++) prg_edge(16'h9000 + 16'(i), 8'(i + 1));
        check_val("t3_err", err_sticky, 2'b01);
        s_prd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t3_commit", prg_mem_wren, 1'b1);
        end
        step();
        check_val("t3_no_more", prg_mem_wren, 1'b0);
        check_val("t3_wr_count", wr_count, 16'h0004);

        // simultaneous PRG/CHR edge
        do_reset();
        s_paddr = 16'h0100; s_pdata = 8'h5A; s_prg_wren = 1'b1; s_chr_wren = 1'b1; step();
        s_prg_wren = 1'b0; s_chr_wren = 1'b0; step();
        check_val("t4_prg_wren", prg_mem_wren, 1'b1);
        check_val("t4_chr_wren", chr_mem_wren, 1'b0);
        step();
        check_val("t4_chr_wren2", chr_mem_wren, 1'b0);
        check_val("t4_err", err_sticky, 2'b10);

        // checksum FF + 02 + 10
        do_reset();
        prg_edge(16'h8000, 8'hFF);
        prg_edge(16'h8001, 8'h02);
        prg_edge(16'h8002, 8'h10);
        step(); step();
        check_val("t6_prg_sum", prg_sum, EXP_SUM3);

        // release timing after the last commit
        t_last = m_last_busy;
        fall = -1;
        for (int n = 0; n < 2000; n++) begin
            step();
            if (nes_reset === 1'b0) begin
                fall = m_cycle - 1;
                break;
            end
        end
        check_val("t5_release", fall - t_last, QC + RH + 1);
        check_val("t5_loading", loading, 1'b0);

        // a new write arriving during HOLD restarts the quiet period
        prg_edge(16'hA000, 8'h33);
        for (int n = 0; n < QC + 4; n++) step();
        prg_edge(16'hA001, 8'h44);
        for (int n = 0; n < 20; n++) step();
        check_val("t7_still_loading", loading, 1'b1);
        check_val("t7_wr_count", wr_count, 16'h0002);

        // randomized traffic with occasional mid-load resets
        for (int r = 0; r < 4000; r++) begin
            s_rst = ($urandom_range(0, 599) == 0);
            if (!s_prg_wren && !s_chr_wren) begin
                s_paddr = 16'($urandom);
                s_pdata = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) s_prg_wren = ~s_prg_wren;
            if ($urandom_range(0, 3) == 0) s_chr_wren = ~s_chr_wren;
            s_prd = ($urandom_range(0, 2) == 0);
            s_crd = ($urandom_range(0, 2) == 0);
            s_prd_addr = 16'($urandom);
            s_crd_addr = 16'($urandom);
            step();
        end
        set_idle();
        for (int n = 0; n < QC + RH + 20; n++) step();
        check_val("final_released", nes_reset, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_prgmr_arbiter.md
Name: rom_prgmr_arbiter

Overview:
- Sequences game-ROM loading from the SoC ROM programmer PIO (addr/data/PRG-wren/CHR-wren) into the on-chip PRG and CHR ROM memories.
- Shares each single-port memory between programmer writes and NES CPU (PRG) and PPU (CHR) reads. NES reads always win.
- Holds the NES in reset for the whole load and releases it a fixed number of cycles after the programmer goes quiet.
- Sits between toplevel_soc and NES_ARCHITECUTRE, clocked on MCLK.

Parameters:
- FIFO_DEPTH, 4: pending-write buffer entries; power of 2, minimum 2.
- QUIET_CYCLES, 1024: idle cycles (no new write, FIFO empty) that end a load.
- RESET_HOLD, 16: cycles nes_reset stays high after the quiet period expires.

Ports:
- Clk  in  1  system clock (MCLK domain)
- Reset  in  1  synchronous, active-high reset
- prgmr_addr  in  16  programmer address; stable while its wren is high
- prgmr_data  in  8  programmer data byte
- prgmr_prg_wren  in  1  level from PIO; a rising edge requests one PRG write
- prgmr_chr_wren  in  1  level from PIO; a rising edge requests one CHR write
- nes_prg_rd  in  1  CPU reads PRG this cycle
- nes_prg_addr  in  16  CPU PRG address
- nes_chr_rd  in  1  PPU reads CHR this cycle
- nes_chr_addr  in  16  PPU CHR address
- prg_mem_addr  out  16  PRG memory address
- prg_mem_data  out  8  PRG write data
- prg_mem_wren  out  1  PRG write enable
- chr_mem_addr  out  16  CHR memory address
- chr_mem_data  out  8  CHR write data
- chr_mem_wren  out  1  CHR write enable
- nes_reset  out  1  NES CPU/PPU reset
- loading  out  1  high from the first accepted write until release
- wr_count  out  16  writes committed since the load started; saturates at FFFF
- err_sticky  out  2  [0] FIFO overflow, [1] simultaneous PRG/CHR edge
- prg_sum  out  8  PRG checksum (see Optional Feature)
- chr_sum  out  8  CHR checksum (see Optional Feature)

Behaviour:
- Reset: FIFO empty; state IDLE; all *_wren 0; mem_addr/data 0; nes_reset 0; loading 0; wr_count 0; err_sticky 0; sums 0.
- Edge detect:
  - Each wren is registered once; a rising edge (prev 0, now 1) pushes {target, addr, data} sampled in the same cycle.
  - Reset clears prev to 0, so a wren already high at reset release counts as an edge.
- Simultaneous PRG and CHR edges: push PRG only, drop CHR, set err_sticky[1].
- FIFO full on push: entry dropped, err_sticky[0] set. A push and a pop in the same cycle with the FIFO full is accepted.
- Drain, one pop per cycle maximum:
  - Head PRG entry: commits when nes_prg_rd=0.
  - Head CHR entry: commits when nes_chr_rd=0.
  - If the matching rd=1, the head stalls in order; no reordering past the head.
- Memory mux (combinational, same cycle):
  - rd=1 → mem_addr = nes address, wren 0.
  - Else if the head commits → mem_addr/data = entry, wren 1.
  - Else → mem_addr = nes address, wren 0.
- Write latency: edge at cycle N → mem_wren at cycle N+1 at the earliest (FIFO registered).
- wr_count increments on each committed write.
- States:
  - IDLE: nes_reset 0. On the first push → LOAD: loading 1, nes_reset 1, wr_count 0, sums 0, err_sticky kept.
  - LOAD: quiet counter cleared by any push or by a non-empty FIFO, otherwise increments. When it reaches QUIET_CYCLES → HOLD.
  - HOLD: counts RESET_HOLD cycles, then → IDLE with nes_reset 0 and loading 0. A push during HOLD → LOAD; counters clear.
- Mid-operation Reset: FIFO flushed, state IDLE, nes_reset 0 on the next cycle. Partially loaded memory contents are untouched.
- err_sticky clears only on Reset.

Optional Feature:
- Macro: ROM_ARB_CHECKSUM_EN.
- Defined: prg_sum/chr_sum = mod-256 sum of committed bytes per target, updated in the commit cycle and cleared on IDLE→LOAD.
- Undefined: no checksum logic; prg_sum and chr_sum tied to 0.

Test Plan:
- Reset, then PRG edge with addr 8000, data A9 and no NES reads → prg_mem_wren=1 one cycle later with addr 8000, data A9; nes_reset=1; loading=1; wr_count=1.
- Hold nes_chr_rd=1 for 5 cycles while 2 CHR writes (0000/11, 0001/22) are pending → chr_mem_wren=0 and chr_mem_addr=nes_chr_addr during the stall; writes then commit in order on consecutive cycles.
- 6 PRG edges on consecutive cycles with nes_prg_rd held high, FIFO_DEPTH=4 → 4 commits after rd drops, err_sticky=01, wr_count=4.
- PRG and CHR edges in the same cycle → only the PRG write commits, err_sticky[1]=1.
- Last write at cycle T, no further activity, QUIET_CYCLES=1024, RESET_HOLD=16 → nes_reset falls at cycle T+1+1024+16 (±1 as documented in RTL), loading falls with it.
- With ROM_ARB_CHECKSUM_EN: PRG bytes FF, 02, 10 → prg_sum=11. Without the macro: prg_sum=00.
